// File: rtl/tx_sequencer.sv
// tx_sequencer: paces the serial transmit datapath through init, repeated send frames and an idle gap.
module tx_sequencer #(
    parameter int MSG_W      = 5,
    parameter int PL_W       = 3,
    parameter int BIT_CYCLES = 16,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [MSG_W-1:0] req_msg,
    input  logic             req_mode,
    input  logic [PL_W-1:0]  req_pl,
    input  logic             abort,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             dp_init,
    output logic             dp_send,
    output logic [MSG_W-1:0] dp_msg,
    output logic             dp_mode,
    output logic [PL_W-1:0]  dp_pl,
    output logic             bit_tick,
    output logic [2:0]       bit_idx
);
    localparam int CW = $clog2((BIT_CYCLES > GAP_CYCLES ? BIT_CYCLES : GAP_CYCLES) + 1);
    localparam logic [CW-1:0] CLAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] GLAST = CW'(GAP_CYCLES - 1);
    localparam logic [2:0]    BLAST = 3'(MSG_W - 1);

    typedef enum logic [1:0] {IDLE, INIT, SEND, GAP} state_t;

    state_t state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0] bit_n;
    logic [PL_W-1:0] rep, rep_n;
    logic ab, ab_n;
    logic accept, ack_n, init_n, send_n, busy_n, done_n, abd_n, tick_n;

    assign accept = (state == IDLE) && req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cyc      <= '0;
            bit_idx  <= '0;
            rep      <= '0;
            ab       <= 1'b0;
            ack      <= 1'b0;
            dp_init  <= 1'b0;
            dp_send  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            bit_tick <= 1'b0;
            dp_msg   <= '0;
            dp_mode  <= 1'b0;
            dp_pl    <= '0;
        end else begin
            state    <= state_n;
            cyc      <= cyc_n;
            bit_idx  <= bit_n;
            rep      <= rep_n;
            ab       <= ab_n;
            ack      <= ack_n;
            dp_init  <= init_n;
            dp_send  <= send_n;
            busy     <= busy_n;
            done     <= done_n;
            aborted  <= abd_n;
            bit_tick <= tick_n;
            if (accept) begin
                dp_msg  <= req_msg;
                dp_mode <= req_mode;
                dp_pl   <= req_pl;
            end
        end
    end

    // cyc times bit periods in SEND and is reused as the gap counter in GAP
    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bit_n   = bit_idx;
        rep_n   = rep;
        ab_n    = ab;
        case (state)
            IDLE: if (req) begin
                state_n = INIT;
                ab_n    = 1'b0;
            end
            INIT: begin
                cyc_n   = '0;
                bit_n   = '0;
                rep_n   = '0;
                state_n = abort ? GAP : SEND;
                ab_n    = abort;
            end
            SEND: if (abort) begin
                state_n = GAP;
                ab_n    = 1'b1;
                cyc_n   = '0;
            end else if (cyc == CLAST) begin
                cyc_n = '0;
                bit_n = (bit_idx == BLAST) ? 3'd0 : 3'(bit_idx + 3'd1);
                if (bit_idx == BLAST) begin
                    rep_n = PL_W'(rep + 1'b1);
                    if (rep == dp_pl) state_n = GAP;
                end
            end else begin
                cyc_n = CW'(cyc + 1'b1);
            end
            GAP: if (cyc == GLAST) state_n = IDLE;
                 else cyc_n = CW'(cyc + 1'b1);
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_n  = accept;
        init_n = accept;
        send_n = state_n == SEND;
        busy_n = state_n != IDLE;
        done_n = (state == GAP) && (state_n == IDLE);
        abd_n  = done_n && ab;
        tick_n = (state_n == SEND) && (cyc_n == CLAST);
    end
endmodule

// File: tb/tb_tx_sequencer.sv
// tb_tx_sequencer: directed requests with a queue-based scoreboard checked at each ack/done.
module tb_tx_sequencer;
    logic clk = 0, rst = 0, req = 0, abort = 0, req_mode = 0;
    logic [4:0] req_msg = '0;
    logic [2:0] req_pl = '0;
    logic ack, busy, done, aborted, dp_init, dp_send, dp_mode, bit_tick;
    logic [4:0] dp_msg;
    logic [2:0] dp_pl, bit_idx;

    tx_sequencer #(.MSG_W(5), .PL_W(3), .BIT_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_msg(req_msg), .req_mode(req_mode),
        .req_pl(req_pl), .abort(abort), .ack(ack), .busy(busy), .done(done),
        .aborted(aborted), .dp_init(dp_init), .dp_send(dp_send), .dp_msg(dp_msg),
        .dp_mode(dp_mode), .dp_pl(dp_pl), .bit_tick(bit_tick), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] msg;
        logic       mode;
        logic [2:0] pl;
        int         len;
        int         ticks;
        logic       ab;
        logic       b2b;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: tracks each transaction and compares against the queue front
    int cyc_no = 0, ack_cyc = 0, done_cyc = -100, last_send = 0, slen = 0, nt = 0;
    logic prev_busy = 0, stable = 1;
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc_no++;
        if (!rst) begin
            q.delete();
            prev_busy = 0;
        end else begin
            if (ack) begin
                chk("ack_while_idle", prev_busy, 0);
                chk("init_with_ack", dp_init, 1);
                if (q.size() == 0) chk("ack_expected", 0, 1);
                else if (q[0].b2b) chk("ack_after_done", cyc_no - done_cyc, 1);
                ack_cyc = cyc_no;
                slen = 0;
                nt = 0;
                stable = 1;
            end
            if (dp_send) begin
                if (slen == 0) chk("send_latency", cyc_no - ack_cyc, 1);
                slen++;
                last_send = cyc_no;
            end
            if (bit_tick) begin
                chk("bit_idx", bit_idx, nt % 5);
                nt++;
            end
            if (busy && q.size() > 0 &&
                (dp_msg !== q[0].msg || dp_mode !== q[0].mode || dp_pl !== q[0].pl))
                stable = 0;
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("send_len", slen, e.len);
                    chk("ticks", nt, e.ticks);
                    chk("aborted", aborted, e.ab);
                    chk("dp_msg", dp_msg, e.msg);
                    chk("dp_mode", dp_mode, e.mode);
                    chk("cfg_stable", stable, 1);
                    chk("done_delay", cyc_no - last_send, 3);
                    chk("busy_at_done", busy, 0);
                end
                done_cyc = cyc_no;
            end
            prev_busy = busy;
        end
    end

    task automatic push(input logic [4:0] m, input logic mo, input logic [2:0] p,
                        input int len, input int t, input logic ab, input logic b2b);
        exp_t e;
        e.msg = m; e.mode = mo; e.pl = p; e.len = len; e.ticks = t; e.ab = ab; e.b2b = b2b;
        q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] m, input logic mo, input logic [2:0] p);
        req_msg = m;
        req_mode = mo;
        req_pl = p;
        req = 1;
    endtask

    task automatic wait_ack();
        int n = 0;
        @(negedge clk);
        while (!ack && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ack) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic issue(input logic [4:0] m, input logic mo, input logic [2:0] p);
        push(m, mo, p, (int'(p) + 1) * 20, (int'(p) + 1) * 5, 0, 0);
        drive(m, mo, p);
        wait_ack();
        @(posedge clk); #1 req = 0;
    endtask

    function automatic int outs();
        return int'({ack, busy, done, aborted, dp_init, dp_send, dp_msg, dp_mode, dp_pl, bit_tick, bit_idx});
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs(), 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        issue(5'b11011, 1, 3'd0);
        wait_done();
        issue(5'b00110, 0, 3'd3);
        repeat (10) @(posedge clk);
        #1 push(5'b10101, 1, 3'd1, 40, 10, 0, 1);
        drive(5'b10101, 1, 3'd1);
        wait_ack();
        @(posedge clk); #1 req = 0;
        wait_done();
        push(5'b01110, 1, 3'd2, 8, 2, 1, 0);
        drive(5'b01110, 1, 3'd2);
        wait_ack();
        @(posedge clk); #1 req = 0;
        repeat (7) @(posedge clk);
        #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        wait_done();
        push(5'b11100, 0, 3'd1, 40, 10, 0, 0);
        drive(5'b11100, 0, 3'd1);
        wait_ack();
        @(posedge clk); #1 req = 0;
        repeat (10) @(posedge clk);
        #2 rst = 0;
        #1 chk("reset_mid_send", outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (60) @(posedge clk);
        #1 chk("idle_after_reset", busy, 0);
        push(5'b01011, 1, 3'd7, 160, 40, 0, 0);
        push(5'b01011, 1, 3'd7, 160, 40, 0, 1);
        drive(5'b01011, 1, 3'd7);
        wait_ack();
        wait_ack();
        @(posedge clk); #1 req = 0;
        wait_done();
        repeat (5) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
